cmp_result_monitor: RTL

Downstream consumer of the 3-bit magnitude comparator. Samples the comparator's one-hot result flags under a valid/ready handshake and keeps saturating per-outcome counts. Detects runs of identical consecutive outcomes and emits a trend report when a run reaches RUN_LEN, so control logic reacts to sustained relationships between A and B rather than to single compares.

---
 rtl/cmp_mon_pkg.sv | 13 +
 rtl/cmp_result_monitor_sat_counter.sv | 18 +
 rtl/cmp_result_monitor.sv | 98 +++++++++
 3 files changed

// File: rtl/cmp_mon_pkg.sv
// cmp_mon_pkg: shared kind codes, monitor states and flag encoder for cmp_result_monitor.
package cmp_mon_pkg;
  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_LT   = 2'b01;
  localparam logic [1:0] KIND_GT   = 2'b10;
  localparam logic [1:0] KIND_EQ   = 2'b11;
  typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_e;
  function automatic logic [1:0] encode(input logic lt, input logic gt, input logic eq);
    return ({lt, gt, eq} == 3'b100) ? KIND_LT :
           ({lt, gt, eq} == 3'b010) ? KIND_GT :
           ({lt, gt, eq} == 3'b001) ? KIND_EQ : KIND_NONE;
  endfunction
endpackage

// File: rtl/cmp_result_monitor_sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: counts comparator outcomes and reports runs of RUN_LEN identical results.
module cmp_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_lt_b,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             err
);
  localparam logic [3:0] RUN_TGT = 4'(RUN_LEN);
  state_e     state_q, state_d;
  logic [1:0] run_kind_q, run_kind_d;
  logic [3:0] run_len_q, run_len_d;
  logic [1:0] out_kind_q, out_kind_d;
  logic       err_q, err_d;
  logic [1:0] kind;
  logic       acc, legal;
  logic [3:0] len_inc;
  assign kind      = encode(a_lt_b, a_gt_b, a_eq_b);
  assign legal     = kind != KIND_NONE;
  assign in_ready  = state_q != REPORT;
  assign acc       = in_valid && in_ready && !clear;
  assign len_inc   = run_len_q + 4'd1;
  assign out_valid = state_q == REPORT;
  assign out_kind  = out_kind_q;
  assign err       = err_q;
  assign err_d     = clear ? 1'b0 : (err_q | (acc && !legal));
  always_comb begin
    state_d    = state_q;
    run_kind_d = run_kind_q;
    run_len_d  = run_len_q;
    out_kind_d = out_kind_q;
    case (state_q)
      IDLE: if (acc && legal) begin
        state_d    = TRACK;
        run_kind_d = kind;
        run_len_d  = 4'd1;
      end
      TRACK: if (acc && !legal) begin
        state_d   = IDLE;
        run_len_d = '0;
      end else if (acc && kind == run_kind_q) begin
        run_len_d = len_inc;
        if (len_inc == RUN_TGT) begin
          state_d    = REPORT;
          out_kind_d = run_kind_q;
        end
      end else if (acc) begin
        run_kind_d = kind;
        run_len_d  = 4'd1;
      end
      REPORT: if (out_ready) begin
        state_d   = IDLE;
        run_len_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // clear overrides any transition decided above, including a pending report
    if (clear) begin
      state_d    = IDLE;
      run_kind_d = KIND_NONE;
      run_len_d  = '0;
      out_kind_d = KIND_NONE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_kind_q <= KIND_NONE;
      run_len_q  <= '0;
      out_kind_q <= KIND_NONE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_kind_q <= run_kind_d;
      run_len_q  <= run_len_d;
      out_kind_q <= out_kind_d;
      err_q      <= err_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_lt (.clk(clk), .rst_n(rst_n), .inc(acc && kind == KIND_LT), .clr(clear), .cnt(lt_cnt));
  sat_counter #(.W(CNT_W)) u_gt (.clk(clk), .rst_n(rst_n), .inc(acc && kind == KIND_GT), .clr(clear), .cnt(gt_cnt));
  sat_counter #(.W(CNT_W)) u_eq (.clk(clk), .rst_n(rst_n), .inc(acc && kind == KIND_EQ), .clr(clear), .cnt(eq_cnt));
endmodule
